wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
Round-robin arbiter that shares one Wishbone slave port (64-bit address/data, 8-bit SEL, 16-bit tags) between NUM_M masters. It owns a registered grant and muxes the granted master's request signals onto the slave. It routes ACK/ERR/RTY back only to the granted master and honours LOCK for indivisible cycles. It sits between the master agents/bridges and the slave-side interface.

Parameters:
NUM_M, 4, number of masters (2..8)
AW, 64, address width
DW, 64, data width
TW, 16, tag width (TGA/TGC/TGD)
TIMEOUT_CYC, 256, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
m_cyc_i  in  NUM_M  per-master CYC
m_stb_i  in  NUM_M  per-master STB
m_we_i  in  NUM_M  per-master WE
m_lock_i  in  NUM_M  per-master LOCK
m_adr_i  in  NUM_M*AW  packed addresses, master i at [i*AW +: AW]
m_dat_i  in  NUM_M*DW  packed write data
m_sel_i  in  NUM_M*8  packed SEL
m_tga_i  in  NUM_M*TW  packed address tags
m_tgc_i  in  NUM_M*TW  packed cycle tags
m_tgd_i  in  NUM_M*TW  packed write data tags
m_dat_o  out  DW  read data, broadcast to all masters
m_tgd_o  out  TW  read data tag, broadcast
m_ack_o  out  NUM_M  ACK, only the granted bit can be high
m_err_o  out  NUM_M  ERR, only the granted bit can be high
m_rty_o  out  NUM_M  RTY, only the granted bit can be high
s_cyc_o, s_stb_o, s_we_o, s_lock_o  out  1 each  slave request controls
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  8  slave SEL
s_tga_o, s_tgc_o, s_tgd_o  out  TW each  slave tags
s_dat_i  in  DW  slave read data
s_tgd_i  in  TW  slave read data tag
s_ack_i, s_err_i, s_rty_i  in  1 each  slave terminations
gnt_o  out  NUM_M  one-hot registered grant, 0 when idle

Behaviour:
- Reset (rst low, asynchronous): gnt_o=0 and FSM=IDLE. Round-robin pointer last=NUM_M-1, so master 0 has first priority. All s_* outputs and all m_ack_o/m_err_o/m_rty_o are 0. Reset asserted mid-cycle aborts the transfer immediately. No termination is forwarded.
- FSM states:
  - IDLE: if any m_cyc_i is high, grant the first requester searching upward from last+1 modulo NUM_M. Register gnt_o, set last to that index, go to BUSY.
  - BUSY: if granted m_cyc_i is high, or granted m_lock_i is high, stay in BUSY. Otherwise clear gnt_o and go to TURN.
  - TURN: one mandatory idle cycle with no grant, then go to IDLE. Arbitration happens in IDLE on the following edge.
- Latency: CYC sampled high in IDLE gives gnt_o and s_cyc_o high on the next cycle. Grant-to-grant gap after a release is at least 2 idle cycles (TURN + IDLE).
- Request mux is combinational from the registered gnt_o:
  - s_cyc_o = |(gnt_o & m_cyc_i); s_stb_o likewise.
  - s_lock_o is the granted master's lock.
  - Data, address, SEL and tag outputs come from the granted slice; they are 0 when gnt_o=0.
- Response routing: m_ack_o = gnt_o & {NUM_M{s_ack_i}}; ERR and RTY the same way. m_dat_o and m_tgd_o pass s_dat_i and s_tgd_i through unmodified.
- LOCK: while the granted master holds LOCK, the grant persists even if its CYC drops between cycles. Other requesters wait indefinitely.
- Simultaneous requests are resolved strictly by rotating priority, so no master starves without LOCK.
- Termination arriving while gnt_o=0 is dropped.
- NUM_M=1: arbiter still runs the FSM, including the TURN cycle.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Defined: a counter clears on grant and on any s_ack_i/s_err_i/s_rty_i. It increments each BUSY cycle in which s_stb_o is high.
  - When it reaches TIMEOUT_CYC-1, the arbiter pulses the granted m_err_o high for one cycle instead of the slave response.
  - On the next edge it forces BUSY to TURN, even under LOCK.
  - The counter resets asynchronously to 0.
- Undefined: no counter, no forced ERR; the arbiter waits indefinitely for a termination.

Test Plan:
- Reset then single request: master 2 raises CYC/STB with ADR=0x1000, WE=1, DAT=0xA5A5 -> gnt_o=4'b0100 next cycle; s_adr_o=0x1000 and s_dat_o=0xA5A5; s_ack_i routed only to m_ack_o[2].
- All four masters request together from reset -> grants in order 0,1,2,3,0, each separated by 2 idle cycles.
- Master 1 asserts LOCK, drops CYC for 3 cycles while master 0 requests -> gnt_o stays 4'b0010 until LOCK falls, then master 0 is granted after TURN.
- Assert rst low mid-transfer while master 3 is granted and STB is high -> gnt_o, s_cyc_o and all m_ack_o are 0 immediately. After reset, a master 3 request is the first one granted only when no lower-index master requests.
- Spurious s_ack_i=1 while gnt_o=0 -> all m_ack_o stay 0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: slave never responds -> m_err_o[granted] pulses on the 8th STB cycle, then gnt_o=0 next cycle. Without the macro, the grant is held indefinitely.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave port through a registered one-hot grant.
// Optional stalled-slave watchdog is compiled in with WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int NUM_M       = 4,
  parameter int AW          = 64,
  parameter int DW          = 64,
  parameter int TW          = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_M-1:0]   m_cyc_i,
  input  logic [NUM_M-1:0]   m_stb_i,
  input  logic [NUM_M-1:0]   m_we_i,
  input  logic [NUM_M-1:0]   m_lock_i,
  input  logic [NUM_M*AW-1:0] m_adr_i,
  input  logic [NUM_M*DW-1:0] m_dat_i,
  input  logic [NUM_M*8-1:0]  m_sel_i,
  input  logic [NUM_M*TW-1:0] m_tga_i,
  input  logic [NUM_M*TW-1:0] m_tgc_i,
  input  logic [NUM_M*TW-1:0] m_tgd_i,
  output logic [DW-1:0]      m_dat_o,
  output logic [TW-1:0]      m_tgd_o,
  output logic [NUM_M-1:0]   m_ack_o,
  output logic [NUM_M-1:0]   m_err_o,
  output logic [NUM_M-1:0]   m_rty_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic               s_lock_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [7:0]         s_sel_o,
  output logic [TW-1:0]      s_tga_o,
  output logic [TW-1:0]      s_tgc_o,
  output logic [TW-1:0]      s_tgd_o,
  input  logic [DW-1:0]      s_dat_i,
  input  logic [TW-1:0]      s_tgd_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  input  logic               s_rty_i,
  output logic [NUM_M-1:0]   gnt_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    pick_s;
  logic             own_cyc_s;
  logic             own_lock_s;
  logic             tmo_hit_s;

  assign own_cyc_s  = |(gnt_q & m_cyc_i);
  assign own_lock_s = |(gnt_q & m_lock_i);

  // Rotating-priority search starting just above the previous winner
  always_comb begin
    int            idx_v;
    logic          found_v;
    logic [IW-1:0] cand_v;
    pick_s  = last_q;
    found_v = 1'b0;
    idx_v   = 0;
    cand_v  = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx_v  = (int'(last_q) + k) % NUM_M;
      cand_v = IW'(idx_v);
      if (!found_v && m_cyc_i[cand_v]) begin
        found_v = 1'b1;
        pick_s  = cand_v;
      end else begin
        found_v = found_v;
      end
    end
  end

  // Grant FSM next state: IDLE arbitrates, BUSY holds on CYC or LOCK, TURN forces one dead cycle
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = NUM_M'(1'b1) << pick_s;
          last_d  = pick_s;
          state_d = ST_BUSY;
        end else begin
          gnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (tmo_hit_s || !(own_cyc_s || own_lock_s)) begin
          gnt_d   = '0;
          state_d = ST_TURN;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_TURN: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Grant FSM state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          any_term_s;

  assign any_term_s = s_ack_i | s_err_i | s_rty_i;
  assign tmo_hit_s  = (state_q == ST_BUSY) && (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));

  // Watchdog: restarts on a new grant or any slave termination, counts strobed BUSY cycles
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == ST_IDLE) && (|m_cyc_i)) begin
      tmo_cnt_d = '0;
    end else if (any_term_s) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_BUSY) && s_stb_o && !tmo_hit_s) begin
      tmo_cnt_d = tmo_cnt_q + CW'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_tmo_s;
  assign tmo_hit_s    = 1'b0;
  assign unused_tmo_s = (TIMEOUT_CYC > 0);
`endif

  // Request mux: OR of all slices masked by the one-hot grant, so an idle grant yields zeros
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_tga_o = '0;
    s_tgc_o = '0;
    s_tgd_o = '0;
    for (int i = 0; i < NUM_M; i++) begin
      s_adr_o = s_adr_o | (m_adr_i[i*AW +: AW] & {AW{gnt_q[i]}});
      s_dat_o = s_dat_o | (m_dat_i[i*DW +: DW] & {DW{gnt_q[i]}});
      s_sel_o = s_sel_o | (m_sel_i[i*8  +: 8]  & {8{gnt_q[i]}});
      s_tga_o = s_tga_o | (m_tga_i[i*TW +: TW] & {TW{gnt_q[i]}});
      s_tgc_o = s_tgc_o | (m_tgc_i[i*TW +: TW] & {TW{gnt_q[i]}});
      s_tgd_o = s_tgd_o | (m_tgd_i[i*TW +: TW] & {TW{gnt_q[i]}});
    end
  end

  assign s_cyc_o  = |(gnt_q & m_cyc_i);
  assign s_stb_o  = |(gnt_q & m_stb_i);
  assign s_we_o   = |(gnt_q & m_we_i);
  assign s_lock_o = own_lock_s;

  // A watchdog expiry replaces whatever the slave returns with ERR
  assign m_ack_o = gnt_q & {NUM_M{s_ack_i & ~tmo_hit_s}};
  assign m_err_o = gnt_q & {NUM_M{s_err_i | tmo_hit_s}};
  assign m_rty_o = gnt_q & {NUM_M{s_rty_i & ~tmo_hit_s}};
  assign m_dat_o = s_dat_i;
  assign m_tgd_o = s_tgd_i;
  assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against an owner/cooldown reference model.
module tb_wb_rr_arbiter;
  localparam int NUM_M = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_M-1:0]    m_cyc_i, m_stb_i, m_we_i, m_lock_i;
  logic [NUM_M*AW-1:0] m_adr_i;
  logic [NUM_M*DW-1:0] m_dat_i;
  logic [NUM_M*8-1:0]  m_sel_i;
  logic [NUM_M*TW-1:0] m_tga_i, m_tgc_i, m_tgd_i;
  logic [DW-1:0]       m_dat_o;
  logic [TW-1:0]       m_tgd_o;
  logic [NUM_M-1:0]    m_ack_o, m_err_o, m_rty_o, gnt_o;
  logic                s_cyc_o, s_stb_o, s_we_o, s_lock_o;
  logic [AW-1:0]       s_adr_o;
  logic [DW-1:0]       s_dat_o;
  logic [7:0]          s_sel_o;
  logic [TW-1:0]       s_tga_o, s_tgc_o, s_tgd_o;
  logic [DW-1:0]       s_dat_i;
  logic [TW-1:0]       s_tgd_i;
  logic                s_ack_i, s_err_i, s_rty_i;

  wb_rr_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .TW(TW), .TIMEOUT_CYC(256)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_lock_i(m_lock_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_tga_i(m_tga_i), .m_tgc_i(m_tgc_i), .m_tgd_i(m_tgd_i),
    .m_dat_o(m_dat_o), .m_tgd_o(m_tgd_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_lock_o(s_lock_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_tga_o(s_tga_o), .s_tgc_o(s_tgc_o), .s_tgd_o(s_tgd_o),
    .s_dat_i(s_dat_i), .s_tgd_i(s_tgd_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] cyc;
    logic [3:0] lock;
    logic       ack;
    logic [3:0] gnt;
    logic [3:0] mack;
    logic       scyc;
  } vec_t;
  vec_t tbl [0:22];

  // reference model: current owner (-1 = none), idle cycles still owed after a release, last winner
  int mo_owner, mo_cool, mo_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_lock_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    m_tga_i = '0; m_tgc_i = '0; m_tgd_i = '0;
    s_dat_i = '0; s_tgd_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic model_init();
    mo_owner = -1;
    mo_cool  = 0;
    mo_last  = NUM_M - 1;
  endtask

  task automatic model_step();
    if (mo_owner >= 0) begin
      if (!(m_cyc_i[mo_owner] || m_lock_i[mo_owner])) begin
        mo_owner = -1;
        mo_cool  = 1;
      end
    end else if (mo_cool > 0) begin
      mo_cool--;
    end else if (|m_cyc_i) begin
      for (int k = 1; k <= NUM_M; k++) begin
        int c;
        c = (mo_last + k) % NUM_M;
        if (m_cyc_i[c]) begin
          mo_owner = c;
          mo_last  = c;
          break;
        end
      end
    end
  endtask

  task automatic model_check();
    logic [63:0] e_gnt, e_cyc, e_stb, e_we, e_lock, e_adr, e_dat, e_sel, e_tga, e_tgc, e_tgd;
    logic [63:0] e_ack, e_err, e_rty;
    int o;
    o = mo_owner;
    e_gnt = '0; e_cyc = '0; e_stb = '0; e_we = '0; e_lock = '0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_tga = '0; e_tgc = '0; e_tgd = '0;
    e_ack = '0; e_err = '0; e_rty = '0;
    if (o >= 0) begin
      e_gnt  = 64'd1 << o;
      e_cyc  = {63'd0, m_cyc_i[o]};
      e_stb  = {63'd0, m_stb_i[o]};
      e_we   = {63'd0, m_we_i[o]};
      e_lock = {63'd0, m_lock_i[o]};
      e_adr  = m_adr_i[o*AW +: AW];
      e_dat  = m_dat_i[o*DW +: DW];
      e_sel  = {56'd0, m_sel_i[o*8 +: 8]};
      e_tga  = {48'd0, m_tga_i[o*TW +: TW]};
      e_tgc  = {48'd0, m_tgc_i[o*TW +: TW]};
      e_tgd  = {48'd0, m_tgd_i[o*TW +: TW]};
      e_ack  = s_ack_i ? e_gnt : 64'd0;
      e_err  = s_err_i ? e_gnt : 64'd0;
      e_rty  = s_rty_i ? e_gnt : 64'd0;
    end
    chk("rnd_gnt", {60'd0, gnt_o}, e_gnt);
    chk("rnd_s_cyc", {63'd0, s_cyc_o}, e_cyc);
    chk("rnd_s_stb", {63'd0, s_stb_o}, e_stb);
    chk("rnd_s_we", {63'd0, s_we_o}, e_we);
    chk("rnd_s_lock", {63'd0, s_lock_o}, e_lock);
    chk("rnd_s_adr", s_adr_o, e_adr);
    chk("rnd_s_dat", s_dat_o, e_dat);
    chk("rnd_s_sel", {56'd0, s_sel_o}, e_sel);
    chk("rnd_s_tga", {48'd0, s_tga_o}, e_tga);
    chk("rnd_s_tgc", {48'd0, s_tgc_o}, e_tgc);
    chk("rnd_s_tgd", {48'd0, s_tgd_o}, e_tgd);
    chk("rnd_m_ack", {60'd0, m_ack_o}, e_ack);
    chk("rnd_m_err", {60'd0, m_err_o}, e_err);
    chk("rnd_m_rty", {60'd0, m_rty_o}, e_rty);
    chk("rnd_m_dat", m_dat_o, s_dat_i);
    chk("rnd_m_tgd", {48'd0, m_tgd_o}, {48'd0, s_tgd_i});
  endtask

  int   exp_order [0:4];
  int   gap;
  logic got;
  logic held;

  initial begin
    clear_inputs();
    //             cyc      lock     ack   gnt      mack     scyc
    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b1};
    tbl[7]  = '{4'b0111, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[10] = '{4'b0110, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[11] = '{4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[12] = '{4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[13] = '{4'b0110, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1};
    tbl[14] = '{4'b0001, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0};
    tbl[15] = '{4'b0001, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0};
    tbl[16] = '{4'b0001, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0};
    tbl[17] = '{4'b0001, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0};
    tbl[18] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[19] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[20] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1};
    tbl[21] = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[22] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;

    // reset values while rst is held low
    #2;
    chk("reset_gnt", {60'd0, gnt_o}, 64'd0);
    chk("reset_s_cyc", {63'd0, s_cyc_o}, 64'd0);

    // single request from master 2 with address/data routing
    do_reset();
    @(negedge clk);
    m_adr_i[2*AW +: AW] = 64'h1000;
    m_dat_i[2*DW +: DW] = 64'hA5A5;
    m_we_i  = 4'b0100;
    m_cyc_i = 4'b0100;
    m_stb_i = 4'b0100;
    #1;
    chk("single_gnt_early", {60'd0, gnt_o}, 64'd0);
    @(negedge clk);
    #1;
    chk("single_gnt", {60'd0, gnt_o}, 64'h4);
    chk("single_adr", s_adr_o, 64'h1000);
    chk("single_dat", s_dat_o, 64'hA5A5);
    chk("single_we", {63'd0, s_we_o}, 64'd1);
    s_ack_i = 1'b1;
    #1;
    chk("single_ack", {60'd0, m_ack_o}, 64'h4);

    // directed vector table: release, rotation, lock hold, spurious terminations
    do_reset();
    for (int r = 0; r <= 22; r++) begin
      @(negedge clk);
      m_cyc_i  = tbl[r].cyc;
      m_stb_i  = tbl[r].cyc;
      m_lock_i = tbl[r].lock;
      s_ack_i  = tbl[r].ack;
      #1;
      chk($sformatf("tbl%0d_gnt", r), {60'd0, gnt_o}, {60'd0, tbl[r].gnt});
      chk($sformatf("tbl%0d_ack", r), {60'd0, m_ack_o}, {60'd0, tbl[r].mack});
      chk($sformatf("tbl%0d_scyc", r), {63'd0, s_cyc_o}, {63'd0, tbl[r].scyc});
      chk($sformatf("tbl%0d_sstb", r), {63'd0, s_stb_o}, {63'd0, tbl[r].scyc});
    end

    // all four masters request together: grant order 0,1,2,3,0 with two idle cycles between
    do_reset();
    for (int n = 0; n < 5; n++) begin
      gap = 0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        m_cyc_i = 4'hF;
        m_stb_i = 4'hF;
        #1;
        if (gnt_o != 4'b0000) got = 1'b1;
        else gap++;
      end
      chk($sformatf("rr%0d_granted", n), {63'd0, got}, 64'd1);
      chk($sformatf("rr%0d_order", n), {60'd0, gnt_o}, 64'd1 << exp_order[n]);
      if (n > 0) chk($sformatf("rr%0d_gap", n), gap, 64'd2);
      m_cyc_i = m_cyc_i & ~gnt_o;
      m_stb_i = m_stb_i & ~gnt_o;
    end

    // asynchronous reset in the middle of a master-3 transfer
    do_reset();
    @(negedge clk);
    m_cyc_i = 4'b1000;
    m_stb_i = 4'b1000;
    @(negedge clk);
    #1;
    chk("mid_gnt_before", {60'd0, gnt_o}, 64'h8);
    s_ack_i = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_gnt_reset", {60'd0, gnt_o}, 64'd0);
    chk("mid_scyc_reset", {63'd0, s_cyc_o}, 64'd0);
    chk("mid_ack_reset", {60'd0, m_ack_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    s_ack_i = 1'b0;
    m_cyc_i = 4'b1010;
    m_stb_i = 4'b1010;
    @(negedge clk);
    #1;
    chk("post_reset_first", {60'd0, gnt_o}, 64'h2);
    m_cyc_i = 4'b1000;
    m_stb_i = 4'b1000;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      #1;
      if (gnt_o != 4'b0000 && gnt_o != 4'b0010) got = 1'b1;
    end
    chk("post_reset_m3_granted", {63'd0, got}, 64'd1);
    chk("post_reset_m3", {60'd0, gnt_o}, 64'h8);

    // no watchdog in this build: silent slave, grant held well past 256 cycles
    do_reset();
    @(negedge clk);
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    @(negedge clk);
    held = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (gnt_o !== 4'b0001 || m_err_o !== 4'b0000) held = 1'b0;
    end
    chk("no_timeout_hold", {63'd0, held}, 64'd1);

    // randomized traffic against the reference model
    do_reset();
    model_init();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_M; i++) begin
        m_cyc_i[i]  = ($urandom_range(0, 3) != 0);
        m_stb_i[i]  = ($urandom_range(0, 3) != 0);
        m_we_i[i]   = $urandom_range(0, 1) == 1;
        m_lock_i[i] = ($urandom_range(0, 7) == 0);
        m_adr_i[i*AW +: AW] = {$urandom, $urandom};
        m_dat_i[i*DW +: DW] = {$urandom, $urandom};
        m_sel_i[i*8 +: 8]   = 8'($urandom);
        m_tga_i[i*TW +: TW] = 16'($urandom);
        m_tgc_i[i*TW +: TW] = 16'($urandom);
        m_tgd_i[i*TW +: TW] = 16'($urandom);
      end
      s_dat_i = {$urandom, $urandom};
      s_tgd_i = 16'($urandom);
      s_ack_i = ($urandom_range(0, 2) == 0);
      s_err_i = ($urandom_range(0, 5) == 0);
      s_rty_i = ($urandom_range(0, 5) == 0);
      #1;
      model_check();
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
